// File: rtl/card_select_ctrl.sv
// Board selection mask controller: turns a mouse click into a board cell index
// and toggles that cell's selection, keeping a running count of selected cells.
module card_select_ctrl #(
    parameter int          MAX_SEL    = 16,
    parameter logic [5:0]  EMPTY_CODE = 6'd54
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [9:0]     mouse_x,
    input  logic [9:0]     mouse_y,
    input  logic           click,
    input  logic           clear,
    input  logic [863:0]   map,
    output logic [143:0]   sel_card,
    output logic [7:0]     sel_cnt,
    output logic           busy,
    output logic [7:0]     hit_pos,
    output logic           reject
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_CHECK  = 2'd2,
        S_APPLY  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [9:0]     mx_q, mx_d;
    logic [9:0]     my_q, my_d;
    logic           valid_q, valid_d;
    logic [7:0]     pos_q, pos_d;
    logic [143:0]   sel_q, sel_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [7:0]     hit_q, hit_d;
    logic           reject_q, reject_d;
    logic [5:0]     cell_code_s;
    logic           reject_cond_s;

    // Same geometry as the display stage: 32-px columns, 46-px row bands with
    // a wider gap between the upper and lower halves. Invalid cells report pos 0.
    function automatic logic [8:0] decode_cell(input logic [9:0] mx, input logic [9:0] my);
        logic       col_v;
        logic [4:0] col;
        logic       row_v;
        logic [2:0] row;
        logic [7:0] pos;
        col_v = (mx >= 10'd32) && (mx < 10'd608);
        col   = 5'((mx - 10'd32) >> 5);
        row_v = 1'b1;
        if (my >= 10'd19 && my < 10'd65) begin
            row = 3'd0;
        end else if (my >= 10'd74 && my < 10'd120) begin
            row = 3'd1;
        end else if (my >= 10'd129 && my < 10'd175) begin
            row = 3'd2;
        end else if (my >= 10'd184 && my < 10'd230) begin
            row = 3'd3;
        end else if (my >= 10'd239 && my < 10'd285) begin
            row = 3'd4;
        end else if (my >= 10'd294 && my < 10'd340) begin
            row = 3'd5;
        end else if (my >= 10'd360 && my < 10'd406) begin
            row = 3'd6;
        end else if (my >= 10'd415 && my < 10'd461) begin
            row = 3'd7;
        end else begin
            row_v = 1'b0;
            row   = 3'd0;
        end
        pos = {3'b000, col} + ({5'b00000, row} * 8'd18);
        if (col_v && row_v) begin
            return {1'b1, pos};
        end else begin
            return 9'd0;
        end
    endfunction

    assign cell_code_s   = map[int'(pos_q) * 6 +: 6];
    assign reject_cond_s = !valid_q || (cell_code_s == EMPTY_CODE) ||
                           (!sel_q[pos_q] && (cnt_q == 8'(MAX_SEL)));

    // Next-state and datapath; clear overrides everything including a pending toggle.
    always_comb begin
        state_d  = state_q;
        mx_d     = mx_q;
        my_d     = my_q;
        valid_d  = valid_q;
        pos_d    = pos_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        reject_d = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            sel_d   = 144'd0;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (click) begin
                        mx_d    = mouse_x;
                        my_d    = mouse_y;
                        state_d = S_DECODE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DECODE: begin
                    {valid_d, pos_d} = decode_cell(mx_q, my_q);
                    state_d          = S_CHECK;
                end
                S_CHECK: begin
                    if (reject_cond_s) begin
                        reject_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        hit_d   = pos_q;
                        state_d = S_APPLY;
                    end
                end
                S_APPLY: begin
                    sel_d[hit_q] = ~sel_q[hit_q];
                    if (sel_q[hit_q]) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_DECODE) || (state_d == S_CHECK);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mx_q     <= 10'd0;
            my_q     <= 10'd0;
            valid_q  <= 1'b0;
            pos_q    <= 8'd0;
            sel_q    <= 144'd0;
            cnt_q    <= 8'd0;
            busy_q   <= 1'b0;
            hit_q    <= 8'd0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            valid_q  <= valid_d;
            pos_q    <= pos_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hit_q    <= hit_d;
            reject_q <= reject_d;
        end
    end

    assign sel_card = sel_q;
    assign sel_cnt  = cnt_q;
    assign busy     = busy_q;
    assign hit_pos  = hit_q;
    assign reject   = reject_q;

endmodule

// File: tb/tb_card_select_ctrl.sv
// Randomized and directed bench for card_select_ctrl against a transaction-level
// model of click handling (geometry by arithmetic, selection kept as a bit set).
module tb_card_select_ctrl;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [9:0]     mouse_x = 10'd0;
    logic [9:0]     mouse_y = 10'd0;
    logic           click = 1'b0;
    logic           clear = 1'b0;
    logic [863:0]   map = 864'd0;
    logic [143:0]   sel_card;
    logic [7:0]     sel_cnt;
    logic           busy;
    logic [7:0]     hit_pos;
    logic           reject;

    int n_cmp  = 0;
    int n_fail = 0;
    int rej_seen = 0;

    int band[8] = '{19, 74, 129, 184, 239, 294, 360, 415};

    card_select_ctrl #(.MAX_SEL(16), .EMPTY_CODE(6'd54)) dut (
        .clk(clk), .rst(rst), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .click(click), .clear(clear), .map(map), .sel_card(sel_card),
        .sel_cnt(sel_cnt), .busy(busy), .hit_pos(hit_pos), .reject(reject)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit [143:0] m_sel;
    bit [7:0]   m_hit;
    bit         m_reject;
    bit         m_busy;
    bit         pend;
    int         age;
    int         pmx, pmy;

    function automatic void geom(input int mx, input int my, output bit v, output int p);
        int col, row;
        col = -1;
        row = -1;
        if (mx >= 32 && mx < 608) col = (mx - 32) / 32;
        for (int r = 0; r < 8; r++)
            if (my >= band[r] && my < band[r] + 46) row = r;
        v = (col >= 0) && (row >= 0);
        p = v ? col + row * 18 : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sel = '0; m_hit = 8'd0; m_reject = 1'b0; m_busy = 1'b0; pend = 1'b0; age = 0;
        end else begin
            m_reject = 1'b0;
            if (clear) begin
                m_sel = '0;
                pend  = 1'b0;
            end else if (pend) begin
                age++;
                if (age == 2) begin
                    bit v; int p;
                    geom(pmx, pmy, v, p);
                    if (!v || map[p*6 +: 6] == 6'd54 || (!m_sel[p] && $countones(m_sel) == 16)) begin
                        m_reject = 1'b1;
                        pend     = 1'b0;
                    end else begin
                        m_hit = 8'(p);
                    end
                end else if (age == 3) begin
                    m_sel[m_hit] = ~m_sel[m_hit];
                    pend = 1'b0;
                end
            end else if (click) begin
                pend = 1'b1; age = 0; pmx = int'(mouse_x); pmy = int'(mouse_y);
            end
            m_busy = pend && (age < 2);
        end
    end

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 30) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("sel_card", sel_card, m_sel);
            chk("sel_cnt", 144'(sel_cnt), 144'($countones(m_sel)));
            chk("busy", 144'(busy), 144'(m_busy));
            chk("hit_pos", 144'(hit_pos), 144'(m_hit));
            chk("reject", 144'(reject), 144'(m_reject));
            if (reject) rej_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_code(input int c, input int code);
        map[c*6 +: 6] = 6'(code);
    endtask

    task automatic cell_xy(input int c, output int x, output int y);
        x = 32 + (c % 18) * 32 + $urandom_range(0, 31);
        y = band[c / 18] + $urandom_range(0, 45);
    endtask

    task automatic do_click(input int x, input int y);
        @(negedge clk);
        mouse_x = 10'(x); mouse_y = 10'(y); click = 1'b1;
        @(negedge clk);
        click = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int x, y, r0, c;
        for (int i = 0; i < 144; i++) set_code(i, i % 50);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_cnt", 144'(sel_cnt), 144'd0);
        chk("reset_busy", 144'(busy), 144'd0);

        // first click on cell 0
        set_code(0, 5);
        do_click(32, 19);
        chk("cell0_sel", 144'(sel_card[0]), 144'd1);
        chk("cell0_cnt", 144'(sel_cnt), 144'd1);
        chk("cell0_hit", 144'(hit_pos), 144'd0);

        // corner cell 143 toggles on and off
        set_code(143, 10);
        do_click(607, 460);
        chk("c143_on", 144'(sel_card[143]), 144'd1);
        chk("c143_cnt2", 144'(sel_cnt), 144'd2);
        chk("c143_hit", 144'(hit_pos), 144'd143);
        do_click(607, 460);
        chk("c143_off", 144'(sel_card[143]), 144'd0);
        chk("c143_cnt1", 144'(sel_cnt), 144'd1);

        // four rejects
        set_code(1, 54);
        r0 = rej_seen;
        do_click(20, 30);
        do_click(100, 67);
        do_click(100, 350);
        do_click(70, 40);
        chk("rej_count", 144'(rej_seen - r0), 144'd4);
        chk("rej_cnt", 144'(sel_cnt), 144'd1);

        // MAX_SEL limit
        do_clear();
        chk("clear_cnt", 144'(sel_cnt), 144'd0);
        set_code(1, 7);
        for (int i = 0; i < 16; i++) begin
            cell_xy(i, x, y);
            do_click(x, y);
        end
        chk("max_cnt16", 144'(sel_cnt), 144'd16);
        r0 = rej_seen;
        cell_xy(16, x, y);
        do_click(x, y);
        chk("max_rej", 144'(rej_seen - r0), 144'd1);
        chk("max_still16", 144'(sel_cnt), 144'd16);
        cell_xy(3, x, y);
        do_click(x, y);
        chk("max_desel", 144'(sel_cnt), 144'd15);
        chk("max_bit3", 144'(sel_card[3]), 144'd0);

        // back-to-back clicks: only the first one lands
        do_clear();
        @(negedge clk);
        cell_xy(20, x, y); mouse_x = 10'(x); mouse_y = 10'(y); click = 1'b1;
        @(negedge clk);
        cell_xy(21, x, y); mouse_x = 10'(x); mouse_y = 10'(y);
        @(negedge clk);
        cell_xy(22, x, y); mouse_x = 10'(x); mouse_y = 10'(y);
        @(negedge clk);
        click = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_cnt", 144'(sel_cnt), 144'd1);
        chk("b2b_bit20", 144'(sel_card[20]), 144'd1);

        // clear together with click
        cell_xy(30, x, y);
        @(negedge clk);
        mouse_x = 10'(x); mouse_y = 10'(y); click = 1'b1; clear = 1'b1;
        @(negedge clk);
        click = 1'b0; clear = 1'b0;
        repeat (5) @(negedge clk);
        chk("clrclk_cnt", 144'(sel_cnt), 144'd0);
        chk("clrclk_bit30", 144'(sel_card[30]), 144'd0);

        // async reset in the middle of APPLY
        cell_xy(40, x, y);
        @(negedge clk);
        mouse_x = 10'(x); mouse_y = 10'(y); click = 1'b1;
        @(negedge clk);
        click = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_sel", sel_card, 144'd0);
        chk("arst_outs", 144'({sel_cnt, busy, hit_pos, reject}), 144'd0);
        @(negedge clk);
        rst = 1'b1;
        do_click(x, y);
        chk("arst_after_cnt", 144'(sel_cnt), 144'd1);
        chk("arst_after_hit", 144'(hit_pos), 144'd40);

        // randomized traffic
        for (int i = 0; i < 144; i++) set_code(i, ($urandom_range(0, 5) == 0) ? 54 : $urandom_range(0, 53));
        repeat (4000) begin
            @(negedge clk);
            click = 1'b0;
            clear = 1'b0;
            if ($urandom_range(0, 99) < 40) begin
                click = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    mouse_x = 10'($urandom_range(0, 639));
                    mouse_y = 10'($urandom_range(0, 479));
                end else begin
                    cell_xy($urandom_range(0, 59), x, y);
                    mouse_x = 10'(x); mouse_y = 10'(y);
                end
            end
            if ($urandom_range(0, 299) == 0) clear = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                c = $urandom_range(0, 143);
                set_code(c, ($urandom_range(0, 3) == 0) ? 54 : $urandom_range(0, 53));
            end
        end
        @(negedge clk);
        click = 1'b0; clear = 1'b0;
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
